// File: rtl/udar_servo_pkg.sv
// Shared constants and helpers for the servo_array pulse generator.
package udar_servo_pkg;

    localparam int unsigned DefPeriod  = 2000;
    localparam int unsigned DefMinW    = 100;
    localparam int unsigned DefTickDiv = 250;

    function automatic int unsigned pos_to_width(int unsigned min_w, int unsigned pos);
        return min_w + pos;
    endfunction

    // Minimum index width able to address ch_num channels.
    function automatic int unsigned ch_idx_width(int unsigned ch_num);
        return (ch_num <= 1) ? 1 : $clog2(ch_num);
    endfunction

endpackage

// File: rtl/servo_array_if.sv
// Target write port of servo_array: valid/ready transfer plus error pulse.
interface servo_array_if #(
    parameter int unsigned CH_LEN  = 2,
    parameter int unsigned POS_LEN = 8
);
    logic               wr_valid;
    logic               wr_ready;
    logic [CH_LEN-1:0]  wr_ch;
    logic [POS_LEN-1:0] wr_pos;
    logic               wr_err;

    modport master (
        output wr_valid, wr_ch, wr_pos,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_ch, wr_pos,
        output wr_ready, wr_err
    );
endinterface

// File: rtl/servo_tick.sv
// Shared tick prescaler and frame counter; frame_start marks the wrap of the
// frame counter and is combinational in the wrap cycle.
module servo_tick #(
    parameter int unsigned TICK_LEN = 12,
    parameter int unsigned TICK_DIV = 250,
    parameter int unsigned PWM_LEN  = 12,
    parameter int unsigned PERIOD   = 2000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               tick,
    output logic [PWM_LEN-1:0] frame_cnt,
    output logic               frame_start
);
    logic [TICK_LEN-1:0] presc_q;
    logic [PWM_LEN-1:0]  frame_q;

    assign tick        = (presc_q == TICK_LEN'(TICK_DIV - 1));
    assign frame_start = tick && (frame_q == PWM_LEN'(PERIOD - 1));
    assign frame_cnt   = frame_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            frame_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + TICK_LEN'(1);
            if (tick) begin
                frame_q <= frame_start ? '0 : frame_q + PWM_LEN'(1);
            end
        end
    end
endmodule

// File: rtl/servo_array.sv
// Multi-channel servo pulse generator with per-frame position slew.
// Build macro SERVO_SLEW_EN: STEP-limited slew; otherwise cur jumps to target each frame.
module servo_array
    import udar_servo_pkg::*;
#(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned CH_LEN   = 2,
    parameter int unsigned POS_LEN  = 8,
    parameter int unsigned TICK_LEN = 12,
    parameter int unsigned TICK_DIV = DefTickDiv,
    parameter int unsigned PWM_LEN  = 12,
    parameter int unsigned PERIOD   = DefPeriod,
    parameter int unsigned MIN_W    = DefMinW,
    parameter int unsigned STEP     = 4,
    parameter int unsigned INIT_POS = 128
) (
    input  logic              clk,
    input  logic              rst,
    servo_array_if.slave      wr_bus,
    output logic              frame_start,
    output logic [CH_NUM-1:0] busy,
    output logic [CH_NUM-1:0] pwm
);
    if (CH_NUM < 1 || CH_NUM > 16) begin : gen_bad_ch_num
        $error("CH_NUM must be 1..16");
    end
    if (CH_LEN < ch_idx_width(CH_NUM)) begin : gen_bad_ch_len
        $error("CH_LEN too narrow for CH_NUM");
    end
    if (MIN_W + 2 ** POS_LEN - 1 >= PERIOD) begin : gen_bad_width
        $error("maximum pulse width must be shorter than PERIOD");
    end
    if (PERIOD >= 2 ** PWM_LEN) begin : gen_bad_period
        $error("PERIOD does not fit PWM_LEN");
    end
    if (TICK_DIV < 2 || TICK_DIV > 2 ** TICK_LEN) begin : gen_bad_tick
        $error("TICK_DIV out of range for TICK_LEN");
    end
    if (STEP == 0) begin : gen_bad_step
        $error("STEP must be non-zero");
    end

    logic               tick;
    logic [PWM_LEN-1:0] frame_cnt;
    logic               frame_upd;
    logic               wr_ready_q;
    logic               wr_err_q;
    logic               wr_accept;
    logic               wr_ch_ok;

    servo_tick #(
        .TICK_LEN (TICK_LEN),
        .TICK_DIV (TICK_DIV),
        .PWM_LEN  (PWM_LEN),
        .PERIOD   (PERIOD)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .frame_cnt   (frame_cnt),
        .frame_start (frame_start)
    );

    assign frame_upd = frame_start & tick;
    assign wr_accept = wr_bus.wr_valid & wr_ready_q;
    assign wr_ch_ok  = ({1'b0, wr_bus.wr_ch} < (CH_LEN + 1)'(CH_NUM));

    assign wr_bus.wr_ready = wr_ready_q;
    assign wr_bus.wr_err   = wr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_ready_q <= 1'b1;
            wr_err_q   <= wr_accept & ~wr_ch_ok;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : gen_ch
        logic [POS_LEN-1:0] tgt_q;
        logic [POS_LEN-1:0] cur_q;
        logic [POS_LEN-1:0] cur_next;
        logic [PWM_LEN-1:0] width;
        logic               busy_q;
        logic               pwm_q;
        logic               wr_hit;

        assign wr_hit = wr_accept && wr_ch_ok && (wr_bus.wr_ch == CH_LEN'(i));
        assign width  = PWM_LEN'(pos_to_width(MIN_W, 32'(cur_q)));

`ifdef SERVO_SLEW_EN
        logic [POS_LEN:0] up_diff;
        logic [POS_LEN:0] dn_diff;

        always_comb begin
            up_diff  = {1'b0, tgt_q} - {1'b0, cur_q};
            dn_diff  = {1'b0, cur_q} - {1'b0, tgt_q};
            cur_next = tgt_q;
            // Moving by STEP only when the gap exceeds STEP, so no over/underflow.
            if (tgt_q >= cur_q) begin
                if (up_diff > (POS_LEN + 1)'(STEP)) cur_next = cur_q + POS_LEN'(STEP);
            end else begin
                if (dn_diff > (POS_LEN + 1)'(STEP)) cur_next = cur_q - POS_LEN'(STEP);
            end
        end
`else
        assign cur_next = tgt_q;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tgt_q  <= POS_LEN'(INIT_POS);
                cur_q  <= POS_LEN'(INIT_POS);
                busy_q <= 1'b0;
                pwm_q  <= 1'b0;
            end else begin
                // Slew reads the pre-write target when both land on the same edge.
                if (frame_upd) cur_q <= cur_next;
                if (wr_hit) tgt_q <= wr_bus.wr_pos;
                busy_q <= (cur_q != tgt_q);
                pwm_q  <= (frame_cnt < width);
            end
        end

        assign busy[i] = busy_q;
        assign pwm[i]  = pwm_q;
    end
endmodule
